memory_access_unit: RTL
=======================

# memory_access_unit

Memory-stage load/store engine between the execute→memory pipeline register and the memory→writeback pipeline register. Turns the M-stage address, store data and funct3 into a word-aligned data-memory transaction with byte enables over a req/ready handshake. Holds the pipeline with `stall_M` until the access completes. Presents the sign- or zero-extended load result as `data_mem_output_M` for capture by the writeback register.

## Interface
Parameters:
- `DATA_W`, 32: data path width. Only 32 is supported.
- `ADDR_W`, 32: byte address width.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `mem_read_M`  in  1  load in M stage.
- `mem_write_M`  in  1  store in M stage.
- `funct3_M`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores accept 000/001/010 only.
- `alu_result_M`  in  ADDR_W  byte address.
- `write_data_M`  in  DATA_W  store data, unaligned in the low bits.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_W  word address: {addr[ADDR_W-1:2], 2'b00}.
- `dmem_wdata`  out  DATA_W  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ready`  in  1  request accepted/completed this cycle.
- `dmem_rdata`  in  DATA_W  read word, valid when `dmem_ready`.
- `data_mem_output_M`  out  DATA_W  extended load result.
- `stall_M`  out  1  freeze F/D/E/M and bubble W.
- `access_fault_M`  out  1  misaligned or illegal access; one-cycle flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - Legal access present (exactly one of read/write, legal funct3, aligned):
    - latch word address, `dmem_we`, be, wdata, funct3, addr[1:0];
    - assert `stall_M`;
    - go to BUSY.
  - No access: `stall_M`=0, `data_mem_output_M`=0.
- **BUSY**
  - `dmem_req`=1; registered request fields held stable.
  - `stall_M`=1.
  - On `dmem_ready`: capture `dmem_rdata` (loads only; stores capture 0); go to DONE.
- **DONE**
  - `stall_M`=0.
  - `data_mem_output_M` = extended captured data.
  - Next state is always IDLE, so the same instruction cannot retrigger.
- **Alignment**
  - H/HU/SH need addr[0]=0; W/SW need addr[1:0]=0.
  - Violation, illegal funct3, or read and write both high:
    - `access_fault_M`=1 for that cycle;
    - no request issued;
    - `stall_M`=0;
    - output 0;
    - FSM stays in IDLE.
- **Store lanes**
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wd[15:0]}}.
  - SW: be = 4'b1111, wdata = wd.
- **Loads**
  - `dmem_be`=4'b1111.
  - Byte or half selected by the latched addr[1:0].
  - B/H sign-extend to 32 bits; BU/HU zero-extend.
- **Reset**
  - State → IDLE; all latched registers → 0.
  - `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `stall_M`, `access_fault_M`, `data_mem_output_M` all 0.
  - Reset during BUSY abandons the request: `dmem_req` is low from the cycle after the reset edge. Memory must tolerate the abandoned request.

## Timing
- Zero-wait memory (`dmem_ready` high in the first BUSY cycle): access occupies 3 cycles in M (IDLE, BUSY, DONE); `stall_M` high for 2.
- Each extra wait cycle adds one BUSY cycle and one stall cycle.
- `dmem_req` is driven from state only; request fields come from registers, so there is no combinational path from M inputs to the memory.
- `stall_M` is combinational from state and M inputs (IDLE with a legal access), so it rises in the same cycle the access is first seen.
- `data_mem_output_M` is valid only in DONE; it is captured by the W register at the DONE→IDLE edge.
- `dmem_ready` outside BUSY is ignored.
- Back-to-back memory ops: the next instruction enters M in the cycle after DONE and starts in IDLE.

## Structure
- Shared package `mem_pkg` holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum `mau_state_t` {IDLE, BUSY, DONE}.
- Sub-module `load_data_extender` is combinational: captured word, addr[1:0] and funct3 in, 32-bit extended result out. It is also reusable in the W stage.

## Test plan
- Load after reset: LW at 0x100, memory returns 0xDEADBEEF with zero wait → `dmem_addr`=0x100, be=1111; stall 2 cycles; DONE output 0xDEADBEEF.
- LB sign / LBU zero: address 0x203, rdata 0x80112233 → LB output 0xFFFFFF80; LBU output 0x00000080.
- SH at 0x302, wd=0x0000ABCD, 3 wait cycles → `dmem_we`=1, be=1100, wdata=0xABCDABCD, addr 0x300; stall 5 cycles.
- Misaligned LW at 0x401 → `access_fault_M`=1 one cycle; `dmem_req` never asserted; `stall_M`=0.
- RST asserted in the second BUSY cycle → next cycle state IDLE, `dmem_req`=0, all outputs 0; a later `dmem_ready` pulse has no effect.
- Back-to-back SW 0x10 then LHU 0x12 returning 0x8001xxxx → two separate transactions, no retrigger; LHU output 0x00008001.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared load/store encodings and M-stage access FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/load_data_extender.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Purely combinational so the W stage can reuse it.
module load_data_extender
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage load/store engine: issues one registered word-aligned dmem request per
// legal access, stalls the pipeline until it completes, and flags illegal accesses.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mem_read_M,
  input  logic              mem_write_M,
  input  logic [2:0]        funct3_M,
  input  logic [ADDR_W-1:0] alu_result_M,
  input  logic [DATA_W-1:0] write_data_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] data_mem_output_M,
  output logic              stall_M,
  output logic              access_fault_M
);

  mau_state_t        state, state_nxt;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ext_data;

  logic              access, size_ok, aligned, legal, launch;
  logic [3:0]        be_new;
  logic [DATA_W-1:0] wdata_new;

  // Legality: size must suit the direction, address must be naturally aligned.
  always_comb begin
    access  = mem_read_M | mem_write_M;
    size_ok = 1'b0;
    aligned = 1'b0;
    case (funct3_M)
      F3_B:  begin size_ok = 1'b1;       aligned = 1'b1;                      end
      F3_H:  begin size_ok = 1'b1;       aligned = ~alu_result_M[0];          end
      F3_W:  begin size_ok = 1'b1;       aligned = (alu_result_M[1:0] == 2'b00); end
      F3_BU: begin size_ok = mem_read_M; aligned = 1'b1;                      end
      F3_HU: begin size_ok = mem_read_M; aligned = ~alu_result_M[0];          end
      default: begin size_ok = 1'b0;     aligned = 1'b0;                      end
    endcase
    legal = (mem_read_M ^ mem_write_M) & size_ok & aligned;
  end

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = '0;
    if (mem_write_M) begin
      case (funct3_M)
        F3_B: begin
          be_new    = 4'b0001 << alu_result_M[1:0];
          wdata_new = {4{write_data_M[7:0]}};
        end
        F3_H: begin
          be_new    = alu_result_M[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{write_data_M[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = write_data_M;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    launch         = 1'b0;
    dmem_req       = 1'b0;
    stall_M        = 1'b0;
    access_fault_M = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          launch    = 1'b1;
          stall_M   = 1'b1;
          state_nxt = BUSY;
        end else if (access) begin
          access_fault_M = 1'b1;
        end
      end
      BUSY: begin
        dmem_req = 1'b1;
        stall_M  = 1'b1;
        if (dmem_ready) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (RST) begin
      stall_M        = 1'b0;
      access_fault_M = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        dmem_we    <= mem_write_M;
        dmem_addr  <= {alu_result_M[ADDR_W-1:2], 2'b00};
        dmem_wdata <= wdata_new;
        dmem_be    <= be_new;
        funct3_q   <= funct3_M;
        offset_q   <= alu_result_M[1:0];
      end
      // Stores complete with a zero result so W never sees stale load data.
      if (state == BUSY && dmem_ready) rdata_q <= dmem_we ? '0 : dmem_rdata;
    end
  end

  load_data_extender u_ext (
    .word   (rdata_q),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  assign data_mem_output_M = (state == DONE) ? ext_data : '0;

endmodule
